// File: rtl/display7seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display7seg_pkg
//  Purpose  : Shared constants and helpers for the multiplexed 7-segment
//             display driver: hex-to-abcdefg table, "all segments off"
//             pattern and width helpers.
//  Contents : seg_t, c_SEG_W, c_NIBBLE_W, c_SEG_OFF, c_HEX_TABLE, digit_w()
//  Revision : 1.0  initial release
// ============================================================================
package display7seg_pkg;

    localparam int c_SEG_W    = 7;
    localparam int c_NIBBLE_W = 4;

    // Segment vector in abcdefg order, seg[6]=a ... seg[0]=g, active-high.
    typedef logic [c_SEG_W-1:0] seg_t;

    // Active-high "nothing lit"; output polarity is applied later.
    localparam seg_t c_SEG_OFF = 7'b000_0000;

    // Hex digit 0..F to abcdefg, active-high (lower-case b and d).
    localparam seg_t c_HEX_TABLE [16] = '{
        7'b111_1110,  // 0
        7'b011_0000,  // 1
        7'b110_1101,  // 2
        7'b111_1001,  // 3
        7'b011_0011,  // 4
        7'b101_1011,  // 5
        7'b101_1111,  // 6
        7'b111_0000,  // 7
        7'b111_1111,  // 8
        7'b111_1011,  // 9
        7'b111_0111,  // A
        7'b001_1111,  // b
        7'b100_1110,  // C
        7'b011_1101,  // d
        7'b100_1111,  // E
        7'b100_0111   // F
    };

    // Width of a digit index; never less than one bit.
    function automatic int digit_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_hex_decode
//  Purpose  : Combinational nibble to abcdefg segment converter
//             (active-high, standard hex glyphs).
//  Ports    : i_nibble   [3:0] hex digit to decode
//             o_abcdefg  [6:0] segments, [6]=a ... [0]=g
//  Revision : 1.0  initial release
// ============================================================================
module seg7_hex_decode
    import display7seg_pkg::*;
(
    input  logic [c_NIBBLE_W-1:0] i_nibble,
    output logic [c_SEG_W-1:0]    o_abcdefg
);

    assign o_abcdefg = c_HEX_TABLE[i_nibble];

endmodule
`default_nettype wire

// File: rtl/display7seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : display7seg_scan
//  Purpose  : Multiplexed N-digit 7-segment display driver. Holds one hex
//             nibble per digit, scans the digits onto shared segment lines,
//             updates the shown value only at frame boundaries, blanks
//             leading zeros, blanks anodes for a guard period at the start
//             of each slot and applies selectable output polarity.
//  Ports    : clk         system clock
//             reset       synchronous active-high reset
//             enable      1 = scanning, 0 = dark with counters held
//             load        strobe capturing value/dp_in
//             value       4*N_DIGITS hex nibbles, [3:0] = digit 0
//             dp_in       decimal point per digit
//             seg         segments, seg[6]=a ... seg[0]=g
//             dp          decimal point of the driven digit
//             an          one-hot digit enable
//             digit_idx   index of the driven digit
//             frame_done  pulse after the last slot of a frame
//  Revision : 1.0  initial release
// ============================================================================
module display7seg_scan
    import display7seg_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            load,
    input  logic [4*N_DIGITS-1:0]           value,
    input  logic [N_DIGITS-1:0]             dp_in,
    output logic [c_SEG_W-1:0]              seg,
    output logic                            dp,
    output logic [N_DIGITS-1:0]             an,
    output logic [digit_w(N_DIGITS)-1:0]    digit_idx,
    output logic                            frame_done
);

    localparam int c_DIGIT_W = digit_w(N_DIGITS);
    localparam int c_PRE_W   = $clog2(REFRESH_DIV);

    localparam logic [c_PRE_W-1:0]   c_PRE_MAX   = c_PRE_W'(REFRESH_DIV - 1);
    localparam logic [c_DIGIT_W-1:0] c_DIGIT_MAX = c_DIGIT_W'(N_DIGITS - 1);

    // XOR masks applied at the register inputs.
    localparam logic [c_SEG_W-1:0]  c_SEG_INV = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic                c_DP_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic [N_DIGITS-1:0] c_AN_INV  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_PRE_W-1:0]    r_prescaler;
    logic [c_DIGIT_W-1:0]  r_digit;
    logic [4*N_DIGITS-1:0] r_shadow;
    logic [N_DIGITS-1:0]   r_shadow_dp;
    logic [4*N_DIGITS-1:0] r_display;
    logic [N_DIGITS-1:0]   r_display_dp;
    logic                  r_pending;

    logic                  w_last_slot;
    logic                  w_frame_bnd;
    logic                  w_in_guard;
    logic [N_DIGITS-1:0]   w_blank;
    logic [c_NIBBLE_W-1:0] w_nibble;
    logic                  w_cur_dp;
    logic                  w_cur_blank;
    logic [c_SEG_W-1:0]    w_abcdefg;
    logic [N_DIGITS-1:0]   w_an_onehot;
    logic [c_SEG_W-1:0]    w_seg_nxt;
    logic                  w_dp_nxt;
    logic [N_DIGITS-1:0]   w_an_nxt;

    assign w_last_slot = (r_prescaler == c_PRE_MAX);
    // Disabled cycles can never be a boundary, so a held counter parked on
    // the last slot does not trigger repeated transfers or pulses.
    assign w_frame_bnd = enable && w_last_slot && (r_digit == c_DIGIT_MAX);

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescaler <= '0;
            r_digit     <= '0;
        end else if (enable) begin
            if (w_last_slot) begin
                r_prescaler <= '0;
                r_digit     <= (r_digit == c_DIGIT_MAX) ? '0 : r_digit + 1'b1;
            end else begin
                r_prescaler <= r_prescaler + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow / display registers: the shown value only changes between
    // frames so a multi-digit number never appears half-updated.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow     <= '0;
            r_shadow_dp  <= '0;
            r_display    <= '0;
            r_display_dp <= '0;
            r_pending    <= 1'b0;
        end else if (load) begin
            r_shadow    <= value;
            r_shadow_dp <= dp_in;
            if (w_frame_bnd) begin
                // Coincident load bypasses the shadow so it is not a frame late.
                r_display    <= value;
                r_display_dp <= dp_in;
                r_pending    <= 1'b0;
            end else begin
                r_pending    <= 1'b1;
            end
        end else if (w_frame_bnd && r_pending) begin
            r_display    <= r_shadow;
            r_display_dp <= r_shadow_dp;
            r_pending    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Guard window at the start of each slot
    // ------------------------------------------------------------------
    generate
        if (GUARD == 0) begin : g_no_guard
            assign w_in_guard = 1'b0;
        end else begin : g_guard
            assign w_in_guard = (r_prescaler < c_PRE_W'(GUARD));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Leading-zero blanking: scan from the top digit down, a digit stays
    // blanked only while every digit from it upward is zero without dp.
    // ------------------------------------------------------------------
    generate
        if (BLANK_LEADING != 0) begin : g_blank
            always_comb begin
                logic w_zero_run;
                w_blank    = '0;
                w_zero_run = 1'b1;
                for (int i = N_DIGITS - 1; i >= 1; i--) begin
                    w_zero_run = w_zero_run && (r_display[4*i +: 4] == 4'h0)
                                 && !r_display_dp[i];
                    w_blank[i] = w_zero_run;
                end
            end
        end else begin : g_no_blank
            assign w_blank = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Current digit selection and decode
    // ------------------------------------------------------------------
    always_comb begin
        w_nibble    = '0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_digit == c_DIGIT_W'(i)) begin
                w_nibble    = r_display[4*i +: 4];
                w_cur_dp    = r_display_dp[i];
                w_cur_blank = w_blank[i];
            end
        end
    end

    seg7_hex_decode u_decode (
        .i_nibble  (w_nibble),
        .o_abcdefg (w_abcdefg)
    );

    assign w_an_onehot = N_DIGITS'(1) << r_digit;

    always_comb begin
        w_seg_nxt = c_SEG_OFF;
        w_dp_nxt  = 1'b0;
        w_an_nxt  = '0;
        if (enable && !w_cur_blank) begin
            w_seg_nxt = w_abcdefg;
            w_dp_nxt  = w_cur_dp;
            // Segments settle on the new digit while the anodes are still dark.
            w_an_nxt  = w_in_guard ? '0 : w_an_onehot;
        end
    end

    // ------------------------------------------------------------------
    // Output registers (polarity applied on the way in)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            seg        <= c_SEG_OFF ^ c_SEG_INV;
            dp         <= c_DP_INV;
            an         <= c_AN_INV;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            seg        <= w_seg_nxt ^ c_SEG_INV;
            dp         <= w_dp_nxt ^ c_DP_INV;
            an         <= w_an_nxt ^ c_AN_INV;
            digit_idx  <= r_digit;
            frame_done <= w_frame_bnd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display7seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display7seg_scan
//  Purpose  : Self-checking bench for display7seg_scan (4 digits, 4 clocks
//             per slot, 1 guard clock, active-low outputs, blanking on).
//  Revision : 1.0  initial release
// ============================================================================
module tb_display7seg_scan;

    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int G     = 1;
    localparam int FRAME = N * RD;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    always #5 clk = ~clk;

    display7seg_scan #(
        .N_DIGITS       (N),
        .REFRESH_DIV    (RD),
        .GUARD          (G),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1),
        .BLANK_LEADING  (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    int tests  = 0;
    int failed = 0;

    // Glyphs written from the digit shapes, abcdefg active-high.
    logic [6:0] glyph [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Reference model: position within the frame plus the visible and
    // waiting contents.
    int          m_t;
    logic [15:0] m_disp, m_shadow;
    logic [3:0]  m_ddp, m_sdp;
    logic        m_pending;

    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic [1:0]  e_idx;
    logic        e_fd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs expected after the coming edge, from state before it.
    task automatic predict();
        int   digit, pres;
        logic blank;
        logic [3:0] nib;
        if (reset) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_idx = 2'd0; e_fd = 1'b0;
        end else begin
            digit = m_t / RD;
            pres  = m_t % RD;
            e_idx = 2'(digit);
            e_fd  = enable && (m_t == FRAME - 1);
            if (!enable) begin
                e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
            end else begin
                nib   = 4'(m_disp >> (4 * digit));
                blank = (digit > 0) && ((m_disp >> (4 * digit)) == 16'h0)
                        && ((m_ddp >> digit) == 4'h0);
                e_seg = blank ? 7'h7F : ~glyph[nib];
                e_dp  = blank ? 1'b1  : ~m_ddp[digit];
                e_an  = (blank || pres < G) ? 4'hF : ~(4'b0001 << digit);
            end
        end
    endtask

    task automatic update();
        logic bnd;
        if (reset) begin
            m_t = 0; m_disp = '0; m_shadow = '0; m_ddp = '0; m_sdp = '0; m_pending = 1'b0;
        end else begin
            bnd = enable && (m_t == FRAME - 1);
            if (load && bnd) begin
                m_disp = value; m_ddp = dp_in; m_shadow = value; m_sdp = dp_in;
                m_pending = 1'b0;
            end else if (load) begin
                m_shadow = value; m_sdp = dp_in; m_pending = 1'b1;
            end else if (bnd && m_pending) begin
                m_disp = m_shadow; m_ddp = m_sdp; m_pending = 1'b0;
            end
            if (enable) m_t = (m_t + 1) % FRAME;
        end
    endtask

    task automatic cycle();
        predict();
        @(posedge clk);
        #1;
        update();
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("an", 32'(an), 32'(e_an));
        check("digit_idx", 32'(digit_idx), 32'(e_idx));
        check("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic run_until(input int pos);
        int n = 0;
        while (m_t != pos && n < 4 * FRAME) begin
            cycle();
            n++;
        end
        check("run_until_bound", 32'(m_t == pos), 32'd1);
    endtask

    // After this, outputs show slot `pos`.
    task automatic slot(input int pos);
        run_until(pos);
        cycle();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load = 1'b1; value = v; dp_in = d;
        cycle();
        load = 1'b0;
    endtask

    initial begin
        int fd_cnt;
        reset = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0;
        m_t = 0; m_disp = '0; m_shadow = '0; m_ddp = '0; m_sdp = '0; m_pending = 1'b0;

        // Reset then idle
        repeat (3) cycle();
        reset = 1'b0;
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_an", 32'(an), 32'hF);
        check("rst_idx", 32'(digit_idx), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);
        enable = 1'b1;

        // Basic scan
        do_load(16'h0012, 4'h0);
        run_until(0);
        cycle();
        check("d0_guard_an", 32'(an), 32'hF);
        check("d0_guard_seg", 32'(seg), 32'h12);
        cycle();
        check("d0_an", 32'(an), 32'hE);
        check("d0_seg", 32'(seg), 32'h12);
        slot(5);
        check("d1_seg", 32'(seg), 32'h4F);
        check("d1_an", 32'(an), 32'hD);
        slot(9);
        check("d2_an", 32'(an), 32'hF);
        check("d2_seg", 32'(seg), 32'h7F);
        slot(13);
        check("d3_an", 32'(an), 32'hF);
        fd_cnt = 0;
        repeat (FRAME) begin
            cycle();
            fd_cnt += int'(frame_done);
        end
        check("fd_per_frame", 32'(fd_cnt), 32'd1);

        // No tearing
        run_until(2);
        do_load(16'h8888, 4'h0);
        slot(5);
        check("tear_old_d1", 32'(seg), 32'h4F);
        slot(13);
        check("tear_old_d3_an", 32'(an), 32'hF);
        slot(1);
        check("tear_new_d0", 32'(seg), 32'h00);
        slot(5);
        check("tear_new_d1", 32'(seg), 32'h00);
        slot(9);
        check("tear_new_d2", 32'(seg), 32'h00);
        slot(13);
        check("tear_new_d3", 32'(seg), 32'h00);
        check("tear_new_d3_an", 32'(an), 32'h7);

        // Load on the frame boundary
        run_until(15);
        do_load(16'hABCD, 4'h0);
        check("bnd_fd", 32'(frame_done), 32'h1);
        slot(1);
        check("bnd_d0", 32'(seg), 32'h42);
        slot(5);
        check("bnd_d1", 32'(seg), 32'h31);
        slot(9);
        check("bnd_d2", 32'(seg), 32'h60);
        slot(13);
        check("bnd_d3", 32'(seg), 32'h08);

        // Decimal point defeats blanking
        run_until(3);
        do_load(16'h0005, 4'b0100);
        dp_in = 4'h0;
        slot(1);
        check("dp_d0", 32'(seg), 32'h24);
        slot(5);
        check("dp_d1_seg", 32'(seg), 32'h01);
        check("dp_d1_an", 32'(an), 32'hD);
        slot(9);
        check("dp_d2_seg", 32'(seg), 32'h01);
        check("dp_d2_dp", 32'(dp), 32'h0);
        check("dp_d2_an", 32'(an), 32'hB);
        slot(13);
        check("dp_d3_an", 32'(an), 32'hF);
        check("dp_d3_seg", 32'(seg), 32'h7F);

        // Enable low mid-frame
        run_until(6);
        enable = 1'b0;
        repeat (10) begin
            cycle();
            check("dis_idx", 32'(digit_idx), 32'h1);
            check("dis_an", 32'(an), 32'hF);
        end
        enable = 1'b1;
        cycle();
        check("resume_idx", 32'(digit_idx), 32'h1);
        check("resume_an", 32'(an), 32'hD);

        // Reset with a load pending
        do_load(16'h0777, 4'h0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        slot(1);
        check("rstp_d0", 32'(seg), 32'h01);
        check("rstp_d0_an", 32'(an), 32'hE);
        slot(5);
        check("rstp_d1_an", 32'(an), 32'hF);
        slot(1);
        check("rstp_next_d0", 32'(seg), 32'h01);
        slot(5);
        check("rstp_next_d1_an", 32'(an), 32'hF);

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            reset  = ($urandom_range(0, 127) == 0);
            enable = ($urandom_range(0, 9) != 0);
            load   = ($urandom_range(0, 5) == 0);
            value  = 16'($urandom);
            // Bias toward leading zeros so blanking gets exercised.
            if ($urandom_range(0, 1) == 1) value = value >> (4 * $urandom_range(1, 3));
            dp_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display7seg_scan.md
Name: display7seg_scan

Overview:
- Multiplexed N-digit 7-segment display driver; successor to the single-digit combinational segment decoders.
- Holds a hex value per digit, decodes each digit 0-F to segments, and time-multiplexes the digits onto shared segment lines with a parametrised refresh rate.
- Adds tear-free frame-synchronous update, leading-zero blanking, decimal points, an anti-ghosting guard, and selectable output polarity.
- Sits between datapath or counter logic and the board display pins.

Parameters:
N_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 50000, clocks per digit slot (>= 2)
GUARD, 1, clocks at the start of each slot with all anodes inactive (0 <= GUARD < REFRESH_DIV)
SEG_ACTIVE_LOW, 1, 1 = segment/dp outputs active-low
AN_ACTIVE_LOW, 1, 1 = anode outputs active-low
BLANK_LEADING, 1, 1 = suppress leading zero digits

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = scanning; 0 = display dark, counters hold
load  input  1  one-cycle strobe that captures value/dp_in
value  input  4*N_DIGITS  hex nibbles; bits [3:0] = digit 0 (rightmost)
dp_in  input  N_DIGITS  decimal point per digit
seg  output  7  segments, seg[6]=a ... seg[0]=g
dp  output  1  decimal point of the current digit
an  output  N_DIGITS  one-hot digit enable
digit_idx  output  $clog2(N_DIGITS) (min 1)  index of the digit currently driven
frame_done  output  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high.
- Values on reset:
  - prescaler=0, digit_idx=0, shadow=0, display=0, pending=0.
  - seg/dp = all off (polarity-applied), an = all inactive, frame_done=0.
- Load and frame-synchronous update:
  - When load=1, value/dp_in are written to the shadow registers and pending=1.
  - A later load before transfer overwrites the shadow; the latest load wins.
  - At a frame boundary with pending=1, shadow is copied to display and pending clears.
  - A frame boundary is the cycle where prescaler=REFRESH_DIV-1 and digit_idx=N_DIGITS-1.
  - If load coincides with a frame boundary, the new load data goes straight into display and pending stays 0.
- Scan:
  - While enable=1, prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit_idx increments and wraps from N_DIGITS-1 to 0.
  - frame_done=1 for exactly the cycle after the frame-boundary cycle.
- Output registering:
  - All outputs are registered and reflect the digit_idx/prescaler state of the previous cycle (latency 1).
  - seg/dp/an are updated together.
- Guard:
  - While the previous-cycle prescaler < GUARD, an = all inactive.
  - seg still shows the new digit during the guard.
- Decode: standard hex, abcdefg active-high form before polarity is applied:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- Blanking (BLANK_LEADING=1):
  - A digit i>0 is blanked if it and every higher digit are 0 and none of those digits has dp set.
  - Digit 0 is never blanked.
  - A blanked digit drives seg off, dp off and its anode inactive for the whole slot.
- Polarity: a 1 in SEG_ACTIVE_LOW or AN_ACTIVE_LOW inverts the corresponding outputs at the register input.
- enable=0:
  - The next cycle drives an all inactive and seg/dp off.
  - prescaler and digit_idx hold; loads are still accepted.
  - A frame boundary never occurs while disabled.
- Reset mid-frame: everything returns to reset values on the next edge, and any pending load is discarded.

Decomposition:
- Shared package display7seg_pkg:
  - 16-entry hex-to-abcdefg constant table.
  - SEG_OFF constant and helper width constants.
- One natural sub-module: seg7_hex_decode, a combinational nibble-to-abcdefg converter.
- Polarity inversion, blanking and scan logic stay in display7seg_scan.

Test Plan:
All scenarios use N_DIGITS=4, REFRESH_DIV=4, GUARD=1, both polarities active-low, BLANK_LEADING=1.
- Reset then idle: hold reset 3 cycles -> seg=7'h7F, dp=1, an=4'hF, digit_idx=0, frame_done=0 in the first cycle after reset release.
- Basic scan:
  - Stimulus: load value=16'h0012, dp_in=0, then wait one frame (16 clks) for the transfer.
  - Digit 0 slot: seg=7'h12, an=4'b1110 (after 1 guard cycle with an=4'hF).
  - Digit 1 slot: seg=7'h4F, an=4'b1101.
  - Digits 2 and 3: an=4'hF, seg=7'h7F.
  - frame_done pulses once every 16 clocks.
- No tearing: load 16'h8888 mid-frame -> old digits shown until the frame boundary; the next frame shows seg=7'h00 on all four slots.
- Load at boundary: assert load exactly on the boundary cycle with 16'hABCD -> the very next frame shows D,C,b,A. Expected seg: D=7'h42, C=7'h31, b=7'h60, A=7'h08.
- dp defeats blanking: value=16'h0005, dp_in=4'b0100 -> digit 2 is lit with seg=7'h01, dp=0; digit 1 is lit with seg=7'h01; digit 3 is blanked.
- enable/reset mid-frame:
  - enable=0 for 10 clks -> an=4'hF and digit_idx frozen; after re-enable the scan resumes from the same index.
  - reset asserted with a load pending -> display=0 and the pending load is lost.
